// File: rtl/icache_dm_pkg.sv
// Shared defaults and refill FSM state encoding for the direct-mapped instruction cache.
package icache_dm_pkg;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_NUM_LINES  = 16;

  typedef enum logic {
    ICS_IDLE   = 1'b0,
    ICS_REFILL = 1'b1
  } ics_state_e;
endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: walks words 0..LINE_WORDS-1 of the missing line over the
// req/ack memory port and produces the array write strobes for the cache top.
module icache_refill_fsm
  import icache_dm_pkg::*;
#(
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES,
  localparam int OFF_W = $clog2(LINE_WORDS),
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int TAG_W = 30 - OFF_W - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_i,
  input  logic [TAG_W-1:0] miss_tag_i,
  input  logic [IDX_W-1:0] miss_idx_i,
  input  logic             flush_i,
  input  logic             imem_ack_i,
  output logic             busy_o,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [OFF_W-1:0] wr_off_o,
  output logic [TAG_W-1:0] wr_tag_o,
  output logic             line_done_o,
  output logic             line_valid_o
);
  ics_state_e       state_q;
  logic [OFF_W-1:0] cnt_q;
  logic [OFF_W-1:0] cnt_nxt;
  logic             kill_q;
  logic             req_q;
  logic [31:0]      addr_q;
  logic [TAG_W-1:0] line_tag_q;
  logic [IDX_W-1:0] line_idx_q;
  logic             ack;
  logic             last;
  logic             start;

  // An ack only counts while a request is outstanding.
  assign ack     = req_q & imem_ack_i;
  assign last    = ack & (cnt_q == OFF_W'(LINE_WORDS - 1));
  assign cnt_nxt = cnt_q + OFF_W'(1);
  assign start   = (state_q == ICS_IDLE) & miss_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ICS_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ICS_IDLE: begin
          if (start) begin
            state_q <= ICS_REFILL;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            req_q   <= 1'b1;
            addr_q  <= {miss_tag_i, miss_idx_i, {OFF_W{1'b0}}, 2'b00};
          end
        end
        ICS_REFILL: begin
          if (flush_i) kill_q <= 1'b1;
          if (ack) begin
            cnt_q <= cnt_nxt;
            if (last) begin
              state_q <= ICS_IDLE;
              req_q   <= 1'b0;
              kill_q  <= 1'b0;
            end else begin
              addr_q <= {line_tag_q, line_idx_q, cnt_nxt, 2'b00};
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      line_tag_q <= miss_tag_i;
      line_idx_q <= miss_idx_i;
    end
  end

  assign busy_o       = (state_q == ICS_REFILL);
  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign wr_en_o      = ack;
  assign wr_idx_o     = line_idx_q;
  assign wr_off_o     = cnt_q;
  assign wr_tag_o     = line_tag_q;
  assign line_done_o  = last;
  // A flush landing on the final ack must also keep the line invalid.
  assign line_valid_o = last & ~kill_q & ~flush_i;
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stalled whole-line refill on miss.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             busy;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [OFF_W-1:0] wr_off;
  logic [TAG_W-1:0] wr_tag;
  logic             line_done;
  logic             line_valid;
  logic             unused_addr_lsb;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  assign off = inst_addr[OFF_W+1:2];
  assign idx = inst_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign tag = inst_addr[31:OFF_W+IDX_W+2];
  assign unused_addr_lsb = ^inst_addr[1:0];

  assign hit        = inst_ren & valid_q[idx] & (tag_q[idx] == tag);
  assign inst_data  = hit ? data_q[{idx, off}] : 32'h0;
  assign inst_stall = busy | (inst_ren & ~hit);

  icache_refill_fsm #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES)
  ) u_refill (
    .clk         (clk),
    .rst         (rst),
    .miss_i      (inst_ren & ~hit),
    .miss_tag_i  (tag),
    .miss_idx_i  (idx),
    .flush_i     (flush),
    .imem_ack_i  (imem_ack),
    .busy_o      (busy),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .wr_en_o     (wr_en),
    .wr_idx_o    (wr_idx),
    .wr_off_o    (wr_off),
    .wr_tag_o    (wr_tag),
    .line_done_o (line_done),
    .line_valid_o(line_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (line_valid) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[{wr_idx, wr_off}] <= imem_rdata;
    if (line_done) tag_q[wr_idx] <= wr_tag;
  end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: reset state, table-driven fetches, refill corner cases, random traffic.
module tb_icache_dm;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        resp_ack;
  logic [31:0] resp_rdata;
  logic        stray_ack;

  int checks = 0;
  int failures = 0;

  // Memory responder configuration and log
  int fixed_lat = 2;
  bit rand_lat = 1'b0;
  int lat_sum = 0;
  logic [31:0] acked[$];

  // Reference model: which line each index holds
  bit   mvalid[16];
  int   mtag[16];

  always #5 clk = ~clk;

  assign imem_ack   = resp_ack | stray_ack;
  assign imem_rdata = stray_ack ? 32'hDEAD_BEEF : resp_rdata;

  icache_dm dut (
    .clk       (clk),
    .rst       (rst),
    .inst_ren  (inst_ren),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .inst_stall(inst_stall),
    .flush     (flush),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata)
  );

  function automatic logic [31:0] mw(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int pick_lat();
    return rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == int'(a[31:8]));
  endfunction

  // Memory side: acks each requested word after the chosen latency.
  initial begin
    int wcnt;
    int cur_lat;
    resp_ack = 1'b0;
    resp_rdata = 32'h0;
    wcnt = 0;
    cur_lat = 0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      resp_rdata = 32'h0;
      if (imem_req) begin
        if (wcnt >= cur_lat) begin
          resp_ack = 1'b1;
          resp_rdata = mw(imem_addr);
          acked.push_back(imem_addr);
          lat_sum += cur_lat + 1;
          wcnt = 0;
          cur_lat = pick_lat();
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        cur_lat = pick_lat();
      end
    end
  end

  // Hold a fetch until the cache stops stalling; returns stall cycles and data.
  task automatic fetch(input logic [31:0] a, output int stalls, output logic [31:0] d, output bit to);
    stalls = 0;
    to = 1'b0;
    acked.delete();
    lat_sum = 0;
    @(negedge clk);
    inst_ren = 1'b1;
    inst_addr = a;
    #1;
    while (inst_stall) begin
      stalls++;
      if (stalls > 300) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    d = inst_data;
  endtask

  // exp_stalls < 0: expect 1 + the refill cycles the memory actually spent.
  task automatic run_fetch(input string nm, input logic [31:0] a, input bit exp_miss, input int exp_stalls);
    int st;
    logic [31:0] d;
    bit to;
    int es;
    fetch(a, st, d, to);
    chk({nm, "_timeout"}, 32'(to), 32'd0);
    es = exp_miss ? ((exp_stalls < 0) ? 1 + lat_sum : exp_stalls) : 0;
    chk({nm, "_stalls"}, 32'(st), 32'(es));
    chk({nm, "_data"}, d, mw(a));
    chk({nm, "_req_idle"}, 32'(imem_req), 32'd0);
    chk({nm, "_nwords"}, 32'(acked.size()), exp_miss ? 32'd4 : 32'd0);
    if (exp_miss) begin
      for (int k = 0; k < 4 && k < acked.size(); k++)
        chk({nm, "_addr"}, acked[k], {a[31:4], 4'h0} + 32'(4 * k));
    end
    mvalid[a[7:4]] = 1'b1;
    mtag[a[7:4]] = int'(a[31:8]);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          miss;
  } vec_t;

  initial begin
    vec_t tbl[11];
    int n;
    int st;
    logic [31:0] d;
    bit to;

    tbl[0]  = '{32'h0000_0040, 1'b1};
    tbl[1]  = '{32'h0000_0044, 1'b0};
    tbl[2]  = '{32'h0000_0048, 1'b0};
    tbl[3]  = '{32'h0000_004C, 1'b0};
    tbl[4]  = '{32'h0000_0140, 1'b1};
    tbl[5]  = '{32'h0000_0144, 1'b0};
    tbl[6]  = '{32'h0000_0040, 1'b1};
    tbl[7]  = '{32'h0000_0050, 1'b1};
    tbl[8]  = '{32'h0000_005C, 1'b0};
    tbl[9]  = '{32'h0000_014C, 1'b1};
    tbl[10] = '{32'h0000_004C, 1'b1};

    rst = 1'b1;
    inst_ren = 1'b0;
    inst_addr = 32'h0;
    flush = 1'b0;
    stray_ack = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) mtag[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(inst_stall), 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    inst_ren = 1'b1;
    inst_addr = 32'h40;
    #1;
    chk("rst_cold_stall", 32'(inst_stall), 32'd1);
    chk("rst_cold_data", inst_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    inst_ren = 1'b0;

    // Table: cold miss, hit sweep, conflict eviction (2-cycle ack latency)
    fixed_lat = 2;
    for (int i = 0; i < 11; i++)
      run_fetch($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].miss, 13);

    // Back-to-back acks on a cold line: 4 REFILL cycles + 1 detect cycle
    fixed_lat = 0;
    run_fetch("b2b", 32'h0000_0200, 1'b1, 5);

    // Flush in IDLE, then flush during refill after the 2nd ack
    @(negedge clk);
    inst_ren = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    fixed_lat = 2;
    fork
      fetch(32'h0000_0040, st, d, to);
      begin
        n = 0;
        while (acked.size() < 2 && n < 200) begin
          @(negedge clk);
          #1;
          n++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    chk("fl_timeout", 32'(to), 32'd0);
    chk("fl_stalls", 32'(st), 32'd26);
    chk("fl_nwords", 32'(acked.size()), 32'd8);
    if (acked.size() == 8) begin
      chk("fl_word3", acked[3], 32'h4C);
      chk("fl_refetch0", acked[4], 32'h40);
      chk("fl_refetch3", acked[7], 32'h4C);
    end
    chk("fl_data", d, mw(32'h40));
    model_clear();
    mvalid[4] = 1'b1;
    mtag[4] = 0;

    // Reset mid-refill after the 1st ack
    @(negedge clk);
    acked.delete();
    inst_ren = 1'b1;
    inst_addr = 32'h0000_0300;
    n = 0;
    while (acked.size() < 1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rm_first_ack", 32'(acked.size()), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    inst_ren = 1'b0;
    @(negedge clk);
    #1;
    chk("rm_req_drop", 32'(imem_req), 32'd0);
    chk("rm_stall", 32'(inst_stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #1;
    chk("rm_stray_req", 32'(imem_req), 32'd0);
    chk("rm_stray_stall", 32'(inst_stall), 32'd0);
    model_clear();
    fixed_lat = 0;
    run_fetch("rm_inval", 32'h0000_0040, 1'b1, 5);
    fixed_lat = 1;
    run_fetch("rm_fresh", 32'h0000_0300, 1'b1, 9);

    // Random traffic against the model
    rand_lat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(4, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        inst_ren = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
      end
      run_fetch($sformatf("rnd%0d", i), a, !model_hit(a), -1);
    end

    @(negedge clk);
    inst_ren = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
